ram_ctrl: RTL and testbench

RAM_CTRL -- requirements
Module: ram_ctrl

---
 rtl/mem_pkg.sv | 27 ++
 rtl/ram_bytes.sv | 45 ++++
 rtl/ram_ctrl.sv | 174 +++++++++++++++++
 tb/tb_ram_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_pkg
//  Purpose  : Shared memory-map constants (ROM and RAM windows) and the
//             2-bit state encoding of the RAM controller FSM.
//  Revision : 1.0  initial release
// ============================================================================
package mem_pkg;

    // ROM window: byte addresses [ROM_BOUND_L, ROM_BOUND_U)
    localparam logic [15:0] ROM_BOUND_L = 16'h0000;
    localparam logic [15:0] ROM_BOUND_U = 16'h0200;

    // Data RAM window: byte addresses [RAM_BOUND_L, RAM_BOUND_U)
    localparam logic [15:0] RAM_BOUND_L = 16'h0200;
    localparam logic [15:0] RAM_BOUND_U = 16'h0A00;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RD    = 2'd1,
        ST_WR_LO = 2'd2,
        ST_WR_HI = 2'd3
    } ram_state_t;

endpackage : mem_pkg
`default_nettype wire

// File: rtl/ram_bytes.sv
`default_nettype none
// ============================================================================
//  Module   : ram_bytes
//  Purpose  : Byte-wide storage array with one synchronous write port and
//             two asynchronous read ports. Contents are never reset.
//  Revision : 1.0  initial release
// ============================================================================
module ram_bytes #(
    parameter int SIZE = 2048,
    parameter int AW   = $clog2(SIZE)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr0,
    output logic [7:0]    rdata0,
    input  logic [AW-1:0] raddr1,
    output logic [7:0]    rdata1
);

    logic [7:0] mem [SIZE];

    // Synchronous byte write
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Asynchronous reads; indices beyond SIZE (only possible when SIZE is
    // not a power of two) return zero instead of an undefined value
    always_comb begin
        rdata0 = 8'h00;
        rdata1 = 8'h00;
        if (32'(raddr0) < SIZE) begin
            rdata0 = mem[raddr0];
        end
        if (32'(raddr1) < SIZE) begin
            rdata1 = mem[raddr1];
        end
    end

endmodule : ram_bytes
`default_nettype wire

// File: rtl/ram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ram_ctrl
//  Purpose  : Single-request RAM controller. Accepts byte/word reads and
//             writes in IDLE, range-checks them against the RAM window,
//             and signals completion with a one-cycle done (and err) pulse.
//  Revision : 1.0  initial release
// ============================================================================
module ram_ctrl
    import mem_pkg::*;
#(
    parameter logic [15:0] BOUND_L = RAM_BOUND_L,
    parameter logic [15:0] BOUND_U = RAM_BOUND_U
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ram_req,
    input  logic        ram_we,
    input  logic        ram_bw,
    input  logic [15:0] ram_addr,
    input  logic [15:0] ram_in,
    output logic [15:0] ram_out,
    output logic        ram_busy,
    output logic        ram_done,
    output logic        ram_err
);

    localparam int SIZE = int'(BOUND_U) - int'(BOUND_L);
    localparam int AW   = $clog2(SIZE);

    // State and captured request
    ram_state_t  state_q, state_d;
    logic        bw_q,    bw_d;
    logic        oor_q,   oor_d;      // captured access lies outside window
    logic [15:0] addr_q,  addr_d;     // aligned byte address
    logic [15:0] data_q,  data_d;

    // Registered outputs
    logic [15:0] out_q,   out_d;
    logic        done_q,  done_d;
    logic        err_q,   err_d;

    // Acceptance-time address handling
    logic [15:0] w_aligned;
    logic [16:0] w_last;
    logic        w_in_win;

    // Storage port signals
    logic [AW-1:0] w_idx_lo;
    logic [AW-1:0] w_idx_hi;
    logic          w_mem_we;
    logic [AW-1:0] w_mem_waddr;
    logic [7:0]    w_mem_wdata;
    logic [7:0]    w_rd_lo;
    logic [7:0]    w_rd_hi;

    // Word accesses are forced even; the last touched byte must sit below
    // the upper bound (17-bit sum so 16'hFFFF cannot wrap into the window)
    always_comb begin
        w_aligned = ram_bw ? ram_addr : {ram_addr[15:1], 1'b0};
        w_last    = {1'b0, w_aligned} + (ram_bw ? 17'd0 : 17'd1);
        w_in_win  = (w_aligned >= BOUND_L) && (w_last < {1'b0, BOUND_U});
    end

    // Array indices for the low and high byte of the captured access
    always_comb begin
        w_idx_lo = AW'(addr_q - BOUND_L);
        w_idx_hi = w_idx_lo + AW'(1);
    end

    // FSM next-state, capture and output computation
    always_comb begin
        state_d     = state_q;
        bw_d        = bw_q;
        oor_d       = oor_q;
        addr_d      = addr_q;
        data_d      = data_q;
        out_d       = out_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_waddr = w_idx_lo;
        w_mem_wdata = data_q[7:0];

        case (state_q)
            ST_IDLE: begin
                if (ram_req) begin
                    bw_d   = ram_bw;
                    addr_d = w_aligned;
                    data_d = ram_in;
                    oor_d  = !w_in_win;
                    // Rejected accesses of either direction take the read
                    // path so they complete in one cycle with no store
                    state_d = (!w_in_win || !ram_we) ? ST_RD : ST_WR_LO;
                end
            end
            ST_RD: begin
                if (oor_q) begin
                    out_d = 16'h0000;
                end else if (bw_q) begin
                    out_d = {8'h00, w_rd_lo};
                end else begin
                    out_d = {w_rd_hi, w_rd_lo};
                end
                done_d  = 1'b1;
                err_d   = oor_q;
                state_d = ST_IDLE;
            end
            ST_WR_LO: begin
                w_mem_we = 1'b1;
                if (bw_q) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WR_HI;
                end
            end
            ST_WR_HI: begin
                w_mem_we    = 1'b1;
                w_mem_waddr = w_idx_hi;
                w_mem_wdata = data_q[15:8];
                done_d      = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset acts immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            bw_q    <= 1'b0;
            oor_q   <= 1'b0;
            addr_q  <= 16'h0000;
            data_q  <= 16'h0000;
            out_q   <= 16'h0000;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bw_q    <= bw_d;
            oor_q   <= oor_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            out_q   <= out_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    ram_bytes #(
        .SIZE (SIZE),
        .AW   (AW)
    ) u_ram_bytes (
        .clk    (clk),
        .we     (w_mem_we),
        .waddr  (w_mem_waddr),
        .wdata  (w_mem_wdata),
        .raddr0 (w_idx_lo),
        .rdata0 (w_rd_lo),
        .raddr1 (w_idx_hi),
        .rdata1 (w_rd_hi)
    );

    assign ram_out  = out_q;
    assign ram_done = done_q;
    assign ram_err  = err_q;
    assign ram_busy = (state_q != ST_IDLE);

endmodule : ram_ctrl
`default_nettype wire

// File: tb/tb_ram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram_ctrl
//  Purpose  : Directed scoreboard bench for ram_ctrl. Each issued access
//             pushes its expected ram_out, ram_err and completion cycle;
//             a monitor pops and compares on every ram_done.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ram_ctrl;

    logic        clk;
    logic        rst;
    logic        ram_req;
    logic        ram_we;
    logic        ram_bw;
    logic [15:0] ram_addr;
    logic [15:0] ram_in;
    logic [15:0] ram_out;
    logic        ram_busy;
    logic        ram_done;
    logic        ram_err;

    typedef struct {
        logic [15:0] out;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_pass;
    int          n_total;
    int          cyc;
    logic [15:0] last_out;

    ram_ctrl u_dut (
        .clk      (clk),
        .rst      (rst),
        .ram_req  (ram_req),
        .ram_we   (ram_we),
        .ram_bw   (ram_bw),
        .ram_addr (ram_addr),
        .ram_in   (ram_in),
        .ram_out  (ram_out),
        .ram_busy (ram_busy),
        .ram_done (ram_done),
        .ram_err  (ram_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every completion must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst && ram_done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'(ram_out), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("ram_out", 32'(ram_out), 32'(e.out));
                chk("ram_err", 32'(ram_err), 32'(e.err));
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
            end
        end else if (!rst && ram_err) begin
            chk("err_without_done", 32'(ram_err), 32'd0);
        end
    end

    // Wait (bounded) until every expectation has been consumed
    task automatic drain(input string name);
        for (int i = 0; i < 10; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
            #1;
        end
        chk(name, 32'(sb.size()), 32'd0);
    endtask

    // Issue one access; called 1 time unit after a rising edge
    task automatic access(input logic we, input logic bw, input logic [15:0] addr,
                          input logic [15:0] din, input logic [15:0] exp_out,
                          input logic exp_err, input int lat, input string name);
        exp_t e;
        ram_req  = 1'b1;
        ram_we   = we;
        ram_bw   = bw;
        ram_addr = addr;
        ram_in   = din;
        e.out = exp_out;
        e.err = exp_err;
        e.cyc = cyc + 1 + lat;
        sb.push_back(e);
        last_out = exp_out;
        @(posedge clk);
        #1;
        ram_req = 1'b0;
        drain(name);
    endtask

    initial begin
        exp_t e;
        int   c;
        n_pass   = 0;
        n_total  = 0;
        cyc      = 0;
        last_out = 16'h0000;
        rst      = 1'b1;
        ram_req  = 1'b0;
        ram_we   = 1'b0;
        ram_bw   = 1'b0;
        ram_addr = 16'h0000;
        ram_in   = 16'h0000;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out",  32'(ram_out),  32'h0);
        chk("rst_done", 32'(ram_done), 32'h0);
        chk("rst_err",  32'(ram_err),  32'h0);
        chk("rst_busy", 32'(ram_busy), 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Word write then read back
        access(1'b1, 1'b0, 16'h0200, 16'hBEEF, 16'h0000, 1'b0, 2, "wr_0200");
        access(1'b0, 1'b0, 16'h0200, 16'h0000, 16'hBEEF, 1'b0, 1, "rd_0200");

        // Byte write into the high byte of a word
        access(1'b1, 1'b0, 16'h0202, 16'h1111, 16'hBEEF, 1'b0, 2, "wr_0202");
        access(1'b1, 1'b1, 16'h0203, 16'h005A, 16'hBEEF, 1'b0, 1, "bwr_0203");
        access(1'b0, 1'b0, 16'h0203, 16'h0000, 16'h5A11, 1'b0, 1, "rd_0203w");
        access(1'b0, 1'b1, 16'h0203, 16'h0000, 16'h005A, 1'b0, 1, "rd_0203b");

        // Top of the window and out-of-window accesses
        access(1'b1, 1'b0, 16'h09FE, 16'hCAFE, 16'h005A, 1'b0, 2, "wr_09FE");
        access(1'b0, 1'b0, 16'h09FE, 16'h0000, 16'hCAFE, 1'b0, 1, "rd_09FE");
        access(1'b1, 1'b1, 16'h01FF, 16'h0077, 16'h0000, 1'b1, 1, "bwr_01FF");
        access(1'b0, 1'b1, 16'h09FF, 16'h0000, 16'h00CA, 1'b0, 1, "rd_09FFb");
        access(1'b0, 1'b0, 16'h0A00, 16'h0000, 16'h0000, 1'b1, 1, "rd_0A00");
        access(1'b0, 1'b0, 16'h09FF, 16'h0000, 16'hCAFE, 1'b0, 1, "rd_09FFw");
        access(1'b1, 1'b0, 16'h0A00, 16'h4321, 16'h0000, 1'b1, 1, "wr_0A00");
        access(1'b0, 1'b0, 16'h0200, 16'h0000, 16'hBEEF, 1'b0, 1, "rd_0200b");

        // Request held high across a word write; follow-on read accepted
        // on the edge that ends the done cycle
        c        = cyc;
        ram_req  = 1'b1;
        ram_we   = 1'b1;
        ram_bw   = 1'b0;
        ram_addr = 16'h0204;
        ram_in   = 16'hA5A5;
        e.out = last_out; e.err = 1'b0; e.cyc = c + 3;
        sb.push_back(e);
        e.out = 16'hA5A5; e.err = 1'b0; e.cyc = c + 5;
        sb.push_back(e);
        last_out = 16'hA5A5;
        @(posedge clk);
        #1;
        ram_we = 1'b0;
        ram_in = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        chk("b2b_busy", 32'(ram_busy), 32'h1);
        ram_req = 1'b0;
        drain("b2b");
        repeat (3) @(posedge clk);
        #1;

        // Reset during the high-byte phase of a word write
        access(1'b1, 1'b0, 16'h0300, 16'hFFFF, 16'hA5A5, 1'b0, 2, "wr_0300");
        ram_req  = 1'b1;
        ram_we   = 1'b1;
        ram_bw   = 1'b0;
        ram_addr = 16'h0300;
        ram_in   = 16'h1234;
        @(posedge clk);
        #1;
        ram_req = 1'b0;
        @(posedge clk);
        #1;
        chk("wrhi_busy", 32'(ram_busy), 32'h1);
        rst = 1'b1;
        #1;
        chk("abort_out",  32'(ram_out),  32'h0);
        chk("abort_busy", 32'(ram_busy), 32'h0);
        chk("abort_done", 32'(ram_done), 32'h0);
        @(posedge clk);
        #5;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_abort_done", 32'(ram_done), 32'h0);
        access(1'b0, 1'b0, 16'h0300, 16'h0000, 16'hFF34, 1'b0, 1, "rd_0300");

        repeat (2) @(posedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Global watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("%0d/%0d checks passed", n_pass, n_total + 1);
        $fatal(1);
    end

endmodule : tb_ram_ctrl
`default_nettype wire
